// File: rtl/mmu_feed_ctrl.sv
// rtl/mmu_feed_ctrl.sv - sequencer that clears, feeds and drains a 2x2 systolic array, then holds its results
module mmu_feed_ctrl #(
    parameter int DRAIN_CYCLES = 2,
    parameter int WIDTH        = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        cfg_transpose,
    input  logic                        cfg_activation,
    output logic                        clear,
    output logic                        data_valid,
    output logic [1:0]                  a0_sel,
    output logic [1:0]                  a1_sel,
    output logic [1:0]                  b0_sel,
    output logic [1:0]                  b1_sel,
    output logic                        transpose,
    output logic                        activation,
    input  logic signed [2*WIDTH-1:0]   c00,
    input  logic signed [2*WIDTH-1:0]   c01,
    input  logic signed [2*WIDTH-1:0]   c10,
    input  logic signed [2*WIDTH-1:0]   c11,
    output logic signed [2*WIDTH-1:0]   res00,
    output logic signed [2*WIDTH-1:0]   res01,
    output logic signed [2*WIDTH-1:0]   res10,
    output logic signed [2*WIDTH-1:0]   res11,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic                        busy,
    output logic                        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_HOLD
    } state_t;

    localparam logic [1:0] SEL_ZERO   = 2'd2;
    localparam logic [1:0] FEED_LAST  = 2'd2;
    localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] feed_cnt;
    logic [2:0] drain_cnt;
    logic       capture;

    assign capture = (state == S_DRAIN) && (drain_cnt == DRAIN_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            feed_cnt   <= 2'd0;
            drain_cnt  <= 3'd0;
            transpose  <= 1'b0;
            activation <= 1'b0;
            res00      <= '0;
            res01      <= '0;
            res10      <= '0;
            res11      <= '0;
            done       <= 1'b0;
        end else begin
            state     <= state_nxt;
            feed_cnt  <= ((state == S_FEED) && (feed_cnt != FEED_LAST)) ? feed_cnt + 2'd1 : 2'd0;
            drain_cnt <= ((state == S_DRAIN) && !capture) ? drain_cnt + 3'd1 : 3'd0;
            done      <= (state == S_HOLD) && res_ready;
            if ((state == S_IDLE) && start) begin
                transpose  <= cfg_transpose;
                activation <= cfg_activation;
            end
            if (capture) begin
                res00 <= c00;
                res01 <= c01;
                res10 <= c10;
                res11 <= c11;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        clear      = 1'b0;
        data_valid = 1'b0;
        a0_sel     = SEL_ZERO;
        a1_sel     = SEL_ZERO;
        b0_sel     = SEL_ZERO;
        b1_sel     = SEL_ZERO;
        res_valid  = 1'b0;
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                clear     = 1'b1;
                state_nxt = S_FEED;
            end
            S_FEED: begin
                data_valid = 1'b1;
                // Skewed wavefront: row/column 1 enters one cycle behind row/column 0.
                case (feed_cnt)
                    2'd0: begin
                        a0_sel = 2'd0; a1_sel = SEL_ZERO; b0_sel = 2'd0; b1_sel = SEL_ZERO;
                    end
                    2'd1: begin
                        a0_sel = 2'd1; a1_sel = 2'd0; b0_sel = 2'd1; b1_sel = 2'd0;
                    end
                    2'd2: begin
                        a0_sel = SEL_ZERO; a1_sel = 2'd1; b0_sel = SEL_ZERO; b1_sel = 2'd1;
                    end
                    default: begin
                        a0_sel = SEL_ZERO; a1_sel = SEL_ZERO; b0_sel = SEL_ZERO; b1_sel = SEL_ZERO;
                    end
                endcase
                if (feed_cnt == FEED_LAST) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (capture) state_nxt = S_HOLD;
            end
            S_HOLD: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule
